// File: rtl/ic_fill_ctrl.sv
// ic_fill_ctrl: I-cache tag/valid lookup, DRAM line-fill sequencer and IF-stage stall timing.
// Define IC_PERF_CNT_EN to build the hit/miss performance counters.
module ic_fill_ctrl #(
  parameter int IWIDTH   = 14,
  parameter int BEAT_LOG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [29:0]       pc_if,
  input  logic              fetch_en,
  input  logic              fence_i,
  output logic              ic_rreq_m_req,
  output logic [27:0]       ic_rreq_m_adr,
  input  logic              ic_rreq_m_ack,
  input  logic              ic_rdat_m_valid,
  output logic [IWIDTH-3:0] ic_ram_wadr_all,
  output logic              ic_stall,
  output logic              ic_stall_dly,
  output logic              ic_stall_fin,
  output logic              ic_stall_fin2,
  output logic [31:0]       ic_hit_cnt,
  output logic [31:0]       ic_miss_cnt
);
  localparam int IXW   = IWIDTH - BEAT_LOG - 2;
  localparam int TW    = 30 - IWIDTH;
  localparam int LW    = 28 - BEAT_LOG;
  localparam int LINES = 1 << IXW;
  typedef enum logic [2:0] {IDLE, REQ, FILL, FIN1, FIN2} state_t;
  state_t              r_state, w_next;
  logic [LINES-1:0]    r_valid;
  logic [TW-1:0]       r_tag [LINES];
  logic [LW-1:0]       r_miss_line;
  logic [BEAT_LOG-1:0] r_beat;
  logic                r_fence_pend;
  logic [IXW-1:0]      w_idx, w_miss_idx;
  logic [TW-1:0]       w_tag, w_miss_tag;
  logic                w_hit, w_miss, w_beat, w_last, w_busy, w_clr, w_unused;
  assign w_idx      = pc_if[IWIDTH-1:BEAT_LOG+2];
  assign w_tag      = pc_if[29:IWIDTH];
  assign w_miss_idx = r_miss_line[IXW-1:0];
  assign w_miss_tag = r_miss_line[LW-1:IXW];
  assign w_unused   = ^pc_if[BEAT_LOG+1:0];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss     = rst_n && (r_state == IDLE) && fetch_en && !w_hit;
  assign w_busy     = (r_state == REQ) || (r_state == FILL);
  assign w_beat     = (r_state == FILL) && ic_rdat_m_valid;
  assign w_last     = w_beat && (&r_beat);
  // A fence seen mid-fill is deferred so the in-flight line is also dropped at FIN1.
  assign w_clr      = (fence_i && !w_busy) || ((r_state == FIN1) && r_fence_pend);
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_miss ? REQ : IDLE;
      REQ:     w_next = ic_rreq_m_ack ? FILL : REQ;
      FILL:    w_next = w_last ? FIN1 : FILL;
      FIN1:    w_next = FIN2;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    ic_stall        = w_miss || w_busy;
    ic_rreq_m_req   = r_state == REQ;
    ic_stall_fin    = r_state == FIN1;
    ic_stall_fin2   = r_state == FIN2;
    ic_rreq_m_adr   = {r_miss_line, {BEAT_LOG{1'b0}}};
    ic_ram_wadr_all = {w_miss_idx, r_beat};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_miss_line  <= '0;
      r_beat       <= '0;
      r_fence_pend <= 1'b0;
      ic_stall_dly <= 1'b0;
    end else begin
      ic_stall_dly <= ic_stall;
      if (w_miss) r_miss_line <= pc_if[29:BEAT_LOG+2];
      if (w_beat) r_beat <= r_beat + BEAT_LOG'(1);
      if (r_state == FIN1) r_fence_pend <= 1'b0;
      else if (fence_i && w_busy) r_fence_pend <= 1'b1;
      if (w_clr) r_valid <= '0;
      else if (w_last) r_valid[w_miss_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst_n && w_last) r_tag[w_miss_idx] <= w_miss_tag;
`ifdef IC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ic_hit_cnt  <= '0;
      ic_miss_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && fetch_en && w_hit) ic_hit_cnt <= ic_hit_cnt + 32'd1;
      if (w_miss) ic_miss_cnt <= ic_miss_cnt + 32'd1;
    end
  end
`else
  assign ic_hit_cnt  = '0;
  assign ic_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_ic_fill_ctrl.sv
// tb_ic_fill_ctrl: directed self-checking bench for ic_fill_ctrl (default IWIDTH=14, BEAT_LOG=2).
module tb_ic_fill_ctrl;
`ifdef IC_PERF_CNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, fetch_en = 1'b0, fence_i = 1'b0, ack = 1'b0, dv = 1'b0;
  logic [29:0] pc_if = '0;
  logic        req, stall, stall_dly, fin, fin2;
  logic [27:0] adr;
  logic [11:0] wadr;
  logic [31:0] hit_cnt, miss_cnt;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  ic_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .fetch_en(fetch_en), .fence_i(fence_i),
    .ic_rreq_m_req(req), .ic_rreq_m_adr(adr), .ic_rreq_m_ack(ack), .ic_rdat_m_valid(dv),
    .ic_ram_wadr_all(wadr), .ic_stall(stall), .ic_stall_dly(stall_dly), .ic_stall_fin(fin),
    .ic_stall_fin2(fin2), .ic_hit_cnt(hit_cnt), .ic_miss_cnt(miss_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Entered in REQ: waits dly cycles, acks, feeds 4 beats, then checks FIN1/FIN2.
  task automatic do_fill(input int dly, input logic beat_with_ack, input logic fence_at2,
                         input logic [27:0] exp_adr, input logic [11:0] base);
    for (int i = 0; i < dly; i++) begin
      #1 chk("req_hold", req, 1); chk("adr_hold", adr, exp_adr);
      tick();
    end
    ack = 1'b1; dv = beat_with_ack;
    #1 chk("req_ack", req, 1); chk("adr_ack", adr, exp_adr); chk("stall_req", stall, 1);
    tick();
    ack = 1'b0; dv = 1'b0;
    #1 chk("req_drop", req, 0);
    for (int i = 0; i < 4; i++) begin
      dv = 1'b1; fence_i = fence_at2 && (i == 2);
      #1 chk("wadr", wadr, base + 12'(i)); chk("stall_fill", stall, 1); chk("fin_fill", fin, 0);
      tick();
    end
    dv = 1'b0; fence_i = 1'b0;
    #1 chk("fin1", fin, 1); chk("stall_fin1", stall, 0); chk("fin2_fin1", fin2, 0);
    chk("dly_fin1", stall_dly, 1);
    tick();
    #1 chk("fin2", fin2, 1); chk("fin_fin2", fin, 0); chk("dly_fin2", stall_dly, 0);
    tick();
  endtask
  initial begin
    // T1: reset, cold miss on 0x1000, full fill
    tick(); tick();
    chk("rst_stall", stall, 0); chk("rst_req", req, 0); chk("rst_adr", adr, 0);
    chk("rst_wadr", wadr, 0); chk("rst_fin", fin, 0); chk("rst_fin2", fin2, 0);
    chk("rst_dly", stall_dly, 0); chk("rst_hit", hit_cnt, 0); chk("rst_miss", miss_cnt, 0);
    rst_n = 1'b1; pc_if = 30'h400; fetch_en = 1'b1;
    #1 chk("t1_miss_stall", stall, 1); chk("t1_req_idle", req, 0);
    tick();
    #1 chk("t1_dly", stall_dly, 1);
    do_fill(0, 1'b0, 1'b0, 28'h100, 12'h100);
    // T2: all 16 words of the line hit
    for (int w = 0; w < 16; w++) begin
      pc_if = 30'h400 + 30'(w);
      #1 chk("t2_hit_stall", stall, 0);
      tick();
    end
    fetch_en = 1'b0;
    #1 chk("t2_hit_cnt", hit_cnt, EN ? 32'd16 : 32'd0); chk("t2_miss_cnt", miss_cnt, EN ? 32'd1 : 32'd0);
    // T3: same index, different tag evicts 0x1000
    fetch_en = 1'b1; pc_if = 30'h4400;
    #1 chk("t3_miss", stall, 1);
    tick();
    do_fill(0, 1'b0, 1'b0, 28'h1100, 12'h100);
    #1 chk("t3_newtag_hit", stall, 0);
    pc_if = 30'h400;
    #1 chk("t3_old_miss", stall, 1);
    tick();
    // T4: ack held off 5 cycles, beat coinciding with ack ignored
    do_fill(5, 1'b1, 1'b0, 28'h100, 12'h100);
    #1 chk("t4_hit", stall, 0);
    tick();
    // T5: fence_i during beat 2 of a fill of 0x2000
    pc_if = 30'h800;
    #1 chk("t5_miss", stall, 1);
    tick();
    do_fill(0, 1'b0, 1'b1, 28'h200, 12'h200);
    #1 chk("t5_fenced_new", stall, 1);
    pc_if = 30'h400;
    #1 chk("t5_fenced_old", stall, 1);
    pc_if = 30'h800;
    tick();
    // T6: reset after two beats, stray beats afterwards
    ack = 1'b1;
    #1 chk("t6_req", req, 1);
    tick();
    ack = 1'b0; dv = 1'b1;
    tick(); tick();
    #1 chk("t6_wadr_mid", wadr, 12'h202);
    rst_n = 1'b0; dv = 1'b0; fetch_en = 1'b0;
    tick();
    #1 chk("t6_stall", stall, 0); chk("t6_req0", req, 0); chk("t6_adr0", adr, 0);
    chk("t6_wadr0", wadr, 0); chk("t6_dly0", stall_dly, 0); chk("t6_fin0", fin, 0);
    chk("t6_hit0", hit_cnt, 0);
    rst_n = 1'b1; dv = 1'b1;
    tick(); tick();
    dv = 1'b0;
    #1 chk("t6_stray_wadr", wadr, 0); chk("t6_stray_stall", stall, 0); chk("t6_stray_fin", fin, 0);
    fetch_en = 1'b1;
    #1 chk("t6_remiss", stall, 1);
    tick();
    do_fill(0, 1'b0, 1'b0, 28'h200, 12'h200);
    #1 chk("t6_hit", stall, 0);
    tick();
    fetch_en = 1'b0;
    #1 chk("t6_hit_cnt", hit_cnt, EN ? 32'd1 : 32'd0); chk("t6_miss_cnt", miss_cnt, EN ? 32'd1 : 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
